// File: rtl/preg_freelist_pkg.sv
// Shared core parameters used by rename, issue, ROB and the physical register free list.
package preg_freelist_pkg;

    localparam int unsigned CORE_PRF_WIDTH  = 6;
    localparam int unsigned CORE_ARF_WIDTH  = 5;
    localparam int unsigned CORE_DECODE_NUM = 4;
    localparam int unsigned CORE_RETIRE_NUM = 4;

endpackage

// File: rtl/preg_freelist_if.sv
// Rename/retire-side bus of the physical register free list.
interface preg_freelist_if
    import preg_freelist_pkg::*;
#(
    parameter int unsigned PRF_WIDTH  = CORE_PRF_WIDTH,
    parameter int unsigned DECODE_NUM = CORE_DECODE_NUM,
    parameter int unsigned RETIRE_NUM = CORE_RETIRE_NUM
);

    logic [DECODE_NUM-1:0]           alloc_req;
    logic                            alloc_ready;
    logic [DECODE_NUM*PRF_WIDTH-1:0] alloc_preg;
    logic [RETIRE_NUM-1:0]           rel_valid;
    logic [RETIRE_NUM*PRF_WIDTH-1:0] rel_preg;
    logic [RETIRE_NUM-1:0]           commit_v;
    logic                            flush;
    logic [PRF_WIDTH:0]              free_count;
    logic                            overflow_err;

    modport master (
        output alloc_req, rel_valid, rel_preg, commit_v, flush,
        input  alloc_ready, alloc_preg, free_count, overflow_err
    );

    modport slave (
        input  alloc_req, rel_valid, rel_preg, commit_v, flush,
        output alloc_ready, alloc_preg, free_count, overflow_err
    );

endinterface

// File: rtl/prefix_cnt.sv
// Per-slot exclusive prefix popcount: prefix_o[i] counts set bits of vec_i below slot i.
module prefix_cnt #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 6,
    parameter int unsigned TW = 7
) (
    input  logic [N-1:0]    vec_i,
    output logic [N*PW-1:0] prefix_o,
    output logic [TW-1:0]   total_o
);

    logic [TW-1:0] acc;

    always_comb begin
        acc      = '0;
        prefix_o = '0;
        for (int i = 0; i < N; i++) begin
            prefix_o[i*PW +: PW] = acc[PW-1:0];
            acc                  = acc + TW'(vec_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/preg_freelist.sv
// Circular free list of physical registers with compacted multi-slot allocate, release,
// commit tracking and flush recovery to the committed head.
module preg_freelist
    import preg_freelist_pkg::*;
#(
    parameter int unsigned PRF_WIDTH  = CORE_PRF_WIDTH,
    parameter int unsigned ARF_WIDTH  = CORE_ARF_WIDTH,
    parameter int unsigned DECODE_NUM = CORE_DECODE_NUM,
    parameter int unsigned RETIRE_NUM = CORE_RETIRE_NUM
) (
    input logic            clk,
    input logic            rst_n,
    preg_freelist_if.slave bus
);

    localparam int unsigned NUM_PREG = 2 ** PRF_WIDTH;
    localparam int unsigned NUM_AREG = 2 ** ARF_WIDTH;
    localparam int unsigned NUM_FREE = NUM_PREG - NUM_AREG;
    localparam int unsigned CW       = PRF_WIDTH + 1;

    logic [PRF_WIDTH-1:0] mem_q [NUM_PREG];
    logic [PRF_WIDTH-1:0] mem_d [NUM_PREG];
    logic [PRF_WIDTH-1:0] head_q, head_d;
    logic [PRF_WIDTH-1:0] chead_q, chead_d;
    logic [PRF_WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;

    logic [DECODE_NUM*PRF_WIDTH-1:0] alloc_off;
    logic [RETIRE_NUM*PRF_WIDTH-1:0] rel_off;
    logic [RETIRE_NUM*PRF_WIDTH-1:0] commit_off;
    logic [CW-1:0]                   nalloc, nrel, ncommit;

    logic                 fire, rel_ok;
    logic [CW-1:0]        nalloc_fired, nrel_ok, left;
    logic [CW:0]          rel_sum, flush_sum;
    logic [PRF_WIDTH-1:0] flush_diff, widx;

    prefix_cnt #(.N(DECODE_NUM), .PW(PRF_WIDTH), .TW(CW)) u_alloc_cnt (
        .vec_i   (bus.alloc_req),
        .prefix_o(alloc_off),
        .total_o (nalloc)
    );

    prefix_cnt #(.N(RETIRE_NUM), .PW(PRF_WIDTH), .TW(CW)) u_rel_cnt (
        .vec_i   (bus.rel_valid),
        .prefix_o(rel_off),
        .total_o (nrel)
    );

    prefix_cnt #(.N(RETIRE_NUM), .PW(PRF_WIDTH), .TW(CW)) u_commit_cnt (
        .vec_i   (bus.commit_v),
        .prefix_o(commit_off),
        .total_o (ncommit)
    );

    // Only the commit total matters; slot positions of commits carry no meaning here.
    logic unused_commit_off;
    assign unused_commit_off = ^commit_off;

    always_comb begin
        bus.alloc_ready = (count_q >= nalloc) && !bus.flush;
        bus.alloc_preg  = '0;
        for (int i = 0; i < DECODE_NUM; i++) begin
            if (bus.alloc_req[i]) begin
                bus.alloc_preg[i*PRF_WIDTH +: PRF_WIDTH] =
                    mem_q[head_q + alloc_off[i*PRF_WIDTH +: PRF_WIDTH]];
            end
        end
    end

    always_comb begin
        fire         = bus.alloc_ready && (|bus.alloc_req);
        nalloc_fired = fire ? nalloc : '0;
        left         = count_q - nalloc_fired;
        // A release batch that would push the count past NUM_PREG is dropped as a whole.
        rel_sum      = {1'b0, left} + {1'b0, nrel};
        rel_ok       = rel_sum <= (CW + 1)'(NUM_PREG);
        nrel_ok      = rel_ok ? nrel : '0;
        ovf_d        = ovf_q | !rel_ok;

        mem_d = mem_q;
        widx  = '0;
        for (int i = 0; i < RETIRE_NUM; i++) begin
            widx = tail_q + rel_off[i*PRF_WIDTH +: PRF_WIDTH];
            if (rel_ok && bus.rel_valid[i]) begin
                mem_d[widx] = bus.rel_preg[i*PRF_WIDTH +: PRF_WIDTH];
            end
        end

        tail_d     = tail_q + nrel_ok[PRF_WIDTH-1:0];
        chead_d    = chead_q + ncommit[PRF_WIDTH-1:0];
        flush_diff = tail_d - chead_d;
        flush_sum  = {1'b0, count_q} + {1'b0, nrel_ok};

        if (bus.flush) begin
            head_d = chead_d;
            // head == tail is ambiguous; any surviving free entry means the ring is full.
            if ((flush_diff == '0) && (flush_sum != '0)) begin
                count_d = CW'(NUM_PREG);
            end else begin
                count_d = {1'b0, flush_diff};
            end
        end else begin
            head_d  = head_q + nalloc_fired[PRF_WIDTH-1:0];
            count_d = count_q - nalloc_fired + nrel_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PREG; i++) begin
                mem_q[i] <= (i < NUM_FREE) ? PRF_WIDTH'(NUM_AREG + i) : '0;
            end
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= PRF_WIDTH'(NUM_FREE);
            count_q <= CW'(NUM_FREE);
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.free_count   = count_q;
    assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_preg_freelist.sv
// Free-list bench: queue-based reference model (free / speculative / architectural pools)
// checked every cycle, directed literal scenarios, then randomized traffic.
module tb_preg_freelist;

    localparam int PW = 6;

    logic clk;
    logic rst_n;

    preg_freelist_if #(.PRF_WIDTH(PW), .DECODE_NUM(4), .RETIRE_NUM(4)) bus ();

    preg_freelist #(
        .PRF_WIDTH (PW),
        .ARF_WIDTH (5),
        .DECODE_NUM(4),
        .RETIRE_NUM(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: every preg lives in exactly one pool.
    int freeq[$];
    int specq[$];
    int ownq[$];
    bit ovf_m;

    logic [3:0] cur_req, cur_relv, cur_cv;
    logic       cur_fl;
    int         cur_relp[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slot(input int i);
        return 32'(bus.alloc_preg[i*PW +: PW]);
    endfunction

    task automatic model_reset();
        freeq.delete();
        specq.delete();
        ownq.delete();
        for (int i = 0; i < 32; i++) ownq.push_back(i);
        for (int i = 32; i < 64; i++) freeq.push_back(i);
        ovf_m = 1'b0;
    endtask

    task automatic model_update();
        int  n, nr, nc;
        bit  fire, relok;
        n     = $countones(cur_req);
        nr    = $countones(cur_relv);
        nc    = $countones(cur_cv);
        fire  = !cur_fl && (n > 0) && (freeq.size() >= n);
        relok = (freeq.size() - (fire ? n : 0) + nr) <= 64;
        if (!relok) ovf_m = 1'b1;
        if (fire) repeat (n) specq.push_back(freeq.pop_front());
        repeat (nc) if (specq.size() > 0) ownq.push_back(specq.pop_front());
        if (cur_fl) while (specq.size() > 0) freeq.push_front(specq.pop_back());
        if (relok) begin
            for (int i = 0; i < 4; i++) if (cur_relv[i]) freeq.push_back(cur_relp[i]);
        end
    endtask

    task automatic check_model();
        int   n, k;
        logic rdy;
        n   = $countones(cur_req);
        rdy = (freeq.size() >= n) && !cur_fl;
        chk("alloc_ready", bus.alloc_ready, rdy);
        chk("free_count", bus.free_count, freeq.size());
        chk("overflow_err", bus.overflow_err, ovf_m);
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (cur_req[i]) begin
                if (rdy) chk($sformatf("grant%0d", i), slot(i), freeq[k]);
                k++;
            end else begin
                chk($sformatf("idle_slot%0d", i), slot(i), 0);
            end
        end
    endtask

    task automatic set_inputs(input logic [3:0] req, input logic [3:0] relv,
                              input int p0, input int p1, input int p2, input int p3,
                              input logic [3:0] cv, input logic fl);
        cur_req     = req;
        cur_relv    = relv;
        cur_cv      = cv;
        cur_fl      = fl;
        cur_relp[0] = p0;
        cur_relp[1] = p1;
        cur_relp[2] = p2;
        cur_relp[3] = p3;
        bus.alloc_req = req;
        bus.rel_valid = relv;
        bus.rel_preg  = {p3[PW-1:0], p2[PW-1:0], p1[PW-1:0], p0[PW-1:0]};
        bus.commit_v  = cv;
        bus.flush     = fl;
    endtask

    task automatic apply(input logic [3:0] req, input logic [3:0] relv = 4'b0,
                         input int p0 = 0, input int p1 = 0, input int p2 = 0,
                         input int p3 = 0, input logic [3:0] cv = 4'b0,
                         input logic fl = 1'b0);
        set_inputs(req, relv, p0, p1, p2, p3, cv, fl);
        #1;
        check_model();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_inputs(4'b0, 4'b0, 0, 0, 0, 0, 4'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_free_count", bus.free_count, 32);
        chk("rst_overflow", bus.overflow_err, 0);
        chk("rst_ready_idle", bus.alloc_ready, 1);
        rst_n = 1'b1;
    endtask

    task automatic remove_own(input int v);
        for (int i = 0; i < ownq.size(); i++) begin
            if (ownq[i] == v) begin
                ownq.delete(i);
                break;
            end
        end
    endtask

    function automatic logic [3:0] limit_bits(input logic [3:0] v, input int maxn);
        int k;
        k          = 0;
        limit_bits = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && (k < maxn)) begin
                limit_bits[i] = 1'b1;
                k++;
            end
        end
    endfunction

    initial begin
        logic [3:0] req, relv, cv;
        logic       fl;
        int         rp[4];
        int         idx;

        rst_n = 1'b0;
        set_inputs(4'b0, 4'b0, 0, 0, 0, 0, 4'b0, 1'b0);

        // Full-width allocation, then the next four
        do_reset();
        apply(4'b1111);
        chk("a1111_s0", slot(0), 32);
        chk("a1111_s1", slot(1), 33);
        chk("a1111_s2", slot(2), 34);
        chk("a1111_s3", slot(3), 35);
        step();
        apply(4'b1111);
        chk("a2_s0", slot(0), 36);
        chk("a2_s3", slot(3), 39);
        chk("a2_count", bus.free_count, 28);
        step();

        // Sparse request compaction
        do_reset();
        apply(4'b1010);
        chk("sparse_s0", slot(0), 0);
        chk("sparse_s1", slot(1), 32);
        chk("sparse_s2", slot(2), 0);
        chk("sparse_s3", slot(3), 33);
        step();
        apply(4'b0000);
        chk("sparse_count", bus.free_count, 30);
        step();

        // Drain to empty, then release 5,7,9
        do_reset();
        repeat (8) begin
            apply(4'b1111);
            step();
        end
        apply(4'b0001);
        chk("empty_count", bus.free_count, 0);
        chk("empty_not_ready", bus.alloc_ready, 0);
        step();
        apply(4'b0000);
        chk("empty_idle_ready", bus.alloc_ready, 1);
        step();
        remove_own(5);
        remove_own(7);
        remove_own(9);
        apply(4'b0001, 4'b0111, 5, 7, 9, 0);
        chk("rel_same_cycle_ready", bus.alloc_ready, 0);
        step();
        apply(4'b1111);
        chk("rel_count", bus.free_count, 3);
        chk("rel_1111_not_ready", bus.alloc_ready, 0);
        step();
        apply(4'b0111);
        chk("rel_s0", slot(0), 5);
        chk("rel_s1", slot(1), 7);
        chk("rel_s2", slot(2), 9);
        chk("rel_ready", bus.alloc_ready, 1);
        step();

        // Flush with two commits restores head past the committed pair
        do_reset();
        apply(4'b1111);
        step();
        apply(4'b1111);
        step();
        apply(4'b1111, 4'b0, 0, 0, 0, 0, 4'b0011, 1'b1);
        chk("flush_not_ready", bus.alloc_ready, 0);
        step();
        apply(4'b0001);
        chk("flush_count", bus.free_count, 30);
        chk("flush_s0", slot(0), 34);
        step();

        // Simultaneous allocate, release and commit
        do_reset();
        remove_own(0);
        remove_own(1);
        apply(4'b1111, 4'b0011, 0, 1, 0, 0, 4'b0001, 1'b0);
        step();
        apply(4'b0000);
        chk("mixed_count", bus.free_count, 30);
        step();

        // Fill to 64, then an illegal release
        do_reset();
        for (int j = 0; j < 8; j++) begin
            for (int b = 0; b < 4; b++) remove_own(4 * j + b);
            apply(4'b0000, 4'b1111, 4 * j, 4 * j + 1, 4 * j + 2, 4 * j + 3);
            step();
        end
        apply(4'b0000);
        chk("full_count", bus.free_count, 64);
        chk("full_no_ovf", bus.overflow_err, 0);
        step();
        apply(4'b0000, 4'b0001, 5, 0, 0, 0);
        step();
        apply(4'b0000);
        chk("ovf_count", bus.free_count, 64);
        chk("ovf_set", bus.overflow_err, 1);
        step();
        repeat (3) begin
            apply(4'b0000);
            step();
        end
        chk("ovf_sticky", bus.overflow_err, 1);
        rst_n = 1'b0;
        #1;
        chk("ovf_cleared", bus.overflow_err, 0);

        // Randomized traffic with pool conservation (at least one architectural preg held)
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            fl   = ($urandom_range(0, 15) == 0);
            cv   = limit_bits(4'($urandom), specq.size());
            relv = limit_bits(4'($urandom), ownq.size() - 1);
            for (int i = 0; i < 4; i++) begin
                if (relv[i]) begin
                    idx   = $urandom_range(0, ownq.size() - 1);
                    rp[i] = ownq[idx];
                    ownq.delete(idx);
                end else begin
                    rp[i] = $urandom_range(0, 63);
                end
            end
            apply(req, relv, rp[0], rp[1], rp[2], rp[3], cv, fl);
            step();
        end

        // Reset asserted mid-operation abandons the pending alloc and release
        apply(4'b1111, 4'b0011, 1, 2, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", bus.free_count, 32);
        chk("midrst_ovf", bus.overflow_err, 0);
        @(posedge clk);
        #1;
        chk("midrst_hold_count", bus.free_count, 32);
        chk("midrst_hold_s0", slot(0), 32);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b0000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
